fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the program counter and issues reads to a synchronous instruction memory.
- Presents one 24-bit instruction per cycle to decode, and honours decode's stall and the branch/jump redirect from execute.
- Detects the all-zero halt word and stops fetching.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_skid_buf.sv | 37 +++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

    localparam int INSTR_W = 24;

    localparam logic [3:0] OP_RTYPE  = 4'b0001;
    localparam logic [3:0] OP_ITYPE  = 4'b0010;
    localparam logic [3:0] OP_BRANCH = 4'b1000;
    localparam logic [3:0] OP_JUMP   = 4'b0100;
    localparam logic [3:0] OP_LOAD   = 4'b1100;
    localparam logic [3:0] OP_STORE  = 4'b0011;

    localparam logic [INSTR_W-1:0] BUBBLE_WORD = 24'hF00000;
    localparam logic [INSTR_W-1:0] HALT_WORD   = 24'h000000;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        HALT
    } fetch_state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word == HALT_WORD;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetch response that lands while decode is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  logic [INSTR_W-1:0] push_data,
    input  logic [PC_W-1:0]    push_pc,
    output logic               full,
    output logic [INSTR_W-1:0] data,
    output logic [PC_W-1:0]    pc
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    // Payload is qualified by full, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data <= push_data;
            pc   <= push_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads synchronous imem, feeds decode with
// stall, redirect and halt-word handling.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 PC_W     = 16,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter logic [INSTR_W-1:0] BUBBLE   = BUBBLE_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc_out,
    output logic               halted
);

    fetch_state_t state_q, state_d;

    logic [PC_W-1:0]    pc_q;
    logic               resp_pending;
    logic [PC_W-1:0]    resp_pc_p1;

    logic               skid_full;
    logic [INSTR_W-1:0] skid_data;
    logic [PC_W-1:0]    skid_pc;

    logic               redir;
    logic               resp_live;
    logic               src_vld;
    logic [INSTR_W-1:0] src_data;
    logic [PC_W-1:0]    src_pc;
    logic               halting;
    logic               skid_push;
    logic               skid_pop;

    // Once halted only reset restarts fetch, so a late redirect is ignored.
    assign redir     = redirect_valid && (state_q != HALT);
    assign resp_live = resp_pending && (state_q == RUN);
    assign src_vld   = skid_full || resp_live;
    assign src_data  = skid_full ? skid_data : imem_rdata;
    assign src_pc    = skid_full ? skid_pc : resp_pc_p1;
    assign halting   = (state_q == RUN) && !redirect_valid && !stall && src_vld && is_halt(src_data);

    assign skid_push = resp_live && stall && !redir;
    assign skid_pop  = skid_full && !stall && !redir;

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALT);

    fetch_skid_buf #(
        .PC_W(PC_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (skid_push),
        .pop      (skid_pop),
        .clear    (redir),
        .push_data(imem_rdata),
        .push_pc  (resp_pc_p1),
        .full     (skid_full),
        .data     (skid_data),
        .pc       (skid_pc)
    );

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            RUN: begin
                imem_req = !stall && !halting;
                if (redir) begin
                    state_d = FLUSH;
                end else if (halting) begin
                    state_d = HALT;
                end
            end
            FLUSH: begin
                imem_req = !stall;
                if (redir) begin
                    state_d = FLUSH;
                end else if (!stall) begin
                    state_d = RUN;
                end
            end
            HALT: begin
                imem_req = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Stage p0: request issue and PC update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            resp_pending <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_pending <= imem_req && !redir;
            if (redir) begin
                pc_q <= redirect_pc;
            end else if (imem_req) begin
                pc_q <= pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) begin
            resp_pc_p1 <= pc_q;
        end
    end

    // Stage p1: response (or skid entry) registered onto the decode interface.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instruction <= BUBBLE;
            instr_valid <= 1'b0;
            pc_out      <= '0;
        end else if (redir) begin
            instruction <= BUBBLE;
            instr_valid <= 1'b0;
        end else if (state_q == HALT || stall) begin
            instruction <= instruction;
            instr_valid <= instr_valid;
        end else if (src_vld) begin
            instruction <= src_data;
            instr_valid <= 1'b1;
            pc_out      <= src_pc;
        end else begin
            instruction <= BUBBLE;
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect/reset
// traffic against a queue-based fetch model.
module tb_fetch_unit;

    localparam logic [23:0] BUB = 24'hF00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [23:0] imem_rdata = 24'h0;
    logic [23:0] instruction;
    logic        instr_valid;
    logic [15:0] pc_out;
    logic        halted;

    logic [23:0] mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    fetch_unit #(
        .PC_W    (16),
        .RESET_PC(16'h0000),
        .BUBBLE  (24'hF00000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
    end

    // Model: addresses requested last cycle (inflight) and words waiting for decode (held).
    bit          m_known = 1'b0;
    logic [15:0] m_pc = 16'h0;
    logic [23:0] m_instr = BUB;
    bit          m_valid = 1'b0;
    logic [15:0] m_pcout = 16'h0;
    bit          m_halted = 1'b0;
    logic [15:0] inflight[$];
    logic [15:0] held[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_req();
        logic [15:0] p;
        bit has;
        if (m_halted || stall) return 1'b0;
        has = 1'b0;
        p = 16'h0;
        if (held.size() > 0) begin
            p = held[0];
            has = 1'b1;
        end else if (inflight.size() > 0) begin
            p = inflight[0];
            has = 1'b1;
        end
        return !(has && mem[p] == 24'h0 && !redirect_valid);
    endfunction

    task automatic model_step();
        bit r;
        bit has;
        logic [15:0] a;
        if (!rst_n) begin
            m_known = 1'b1;
            m_pc = 16'h0;
            inflight.delete();
            held.delete();
            m_instr = BUB;
            m_valid = 1'b0;
            m_pcout = 16'h0;
            m_halted = 1'b0;
            return;
        end
        if (!m_known) return;
        r = model_req();
        has = 1'b0;
        a = 16'h0;
        if (inflight.size() > 0) begin
            a = inflight.pop_front();
            has = 1'b1;
        end
        if (m_halted) begin
        end else if (redirect_valid) begin
            held.delete();
            m_pc = redirect_pc;
            m_instr = BUB;
            m_valid = 1'b0;
        end else begin
            if (has) held.push_back(a);
            if (!stall) begin
                if (held.size() > 0) begin
                    a = held.pop_front();
                    m_instr = mem[a];
                    m_valid = 1'b1;
                    m_pcout = a;
                    if (mem[a] == 24'h0) m_halted = 1'b1;
                end else begin
                    m_instr = BUB;
                    m_valid = 1'b0;
                end
                if (r) begin
                    inflight.push_back(m_pc);
                    m_pc = m_pc + 16'h1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && m_known) begin
            check("instruction", 32'(instruction), 32'(m_instr));
            check("instr_valid", 32'(instr_valid), 32'(m_valid));
            check("pc_out", 32'(pc_out), 32'(m_pcout));
            check("halted", 32'(halted), 32'(m_halted));
            check("imem_req", 32'(imem_req), 32'(model_req()));
            if (model_req()) check("imem_addr", 32'(imem_addr), 32'(m_pc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            step();
            cyc++;
        end
    endtask

    task automatic reset_low();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        step();
    endtask

    task automatic reset_release();
        step();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic expect_word(input string nm, input logic [23:0] w, input logic [15:0] p);
        check({nm, ".instr"}, 32'(instruction), 32'(w));
        check({nm, ".valid"}, 32'(instr_valid), 32'(1'b1));
        check({nm, ".pc"}, 32'(pc_out), 32'(p));
    endtask

    task automatic expect_bubble(input string nm);
        check({nm, ".instr"}, 32'(instruction), 32'(BUB));
        check({nm, ".valid"}, 32'(instr_valid), 32'(1'b0));
    endtask

    task automatic redirect_case(input bit with_stall);
        reset_low();
        reset_release();
        goto(5);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        stall = with_stall;
        goto(6);
        redirect_valid = 1'b0;
        stall = 1'b0;
        expect_bubble("redir_c6");
        goto(7);
        expect_bubble("redir_c7");
        goto(8);
        expect_word("redir_c8", 24'h100040, 16'h0040);
        goto(9);
        expect_word("redir_c9", 24'h100041, 16'h0041);
    endtask

    initial begin
        logic [23:0] w;

        // Directed: sequential fetch and stall/skid behaviour.
        reset_low();
        for (int a = 0; a < 65536; a++) mem[a] = 24'h100000 + 24'(a);
        reset_release();
        check("rst.instr", 32'(instruction), 32'(BUB));
        check("rst.valid", 32'(instr_valid), 32'(1'b0));
        check("rst.pc_out", 32'(pc_out), 32'h0);
        check("rst.halted", 32'(halted), 32'h0);
        check("rst.addr", 32'(imem_addr), 32'h0);
        goto(2);
        expect_word("seq_c2", 24'h100000, 16'h0);
        goto(3);
        expect_word("seq_c3", 24'h100001, 16'h1);
        goto(4);
        stall = 1'b1;
        expect_word("stall_c4", 24'h100002, 16'h2);
        goto(5);
        expect_word("stall_c5", 24'h100002, 16'h2);
        goto(6);
        expect_word("stall_c6", 24'h100002, 16'h2);
        goto(7);
        stall = 1'b0;
        expect_word("stall_c7", 24'h100002, 16'h2);
        goto(8);
        expect_word("skid_c8", 24'h100003, 16'h3);
        goto(9);
        expect_word("resume_c9", 24'h100004, 16'h4);
        goto(10);
        expect_word("resume_c10", 24'h100005, 16'h5);

        redirect_case(1'b0);
        redirect_case(1'b1);

        // Halt word at address 3.
        reset_low();
        mem[3] = 24'h000000;
        reset_release();
        goto(5);
        expect_word("halt_c5", 24'h000000, 16'h3);
        goto(6);
        check("halt_c6.halted", 32'(halted), 32'h1);
        for (int i = 0; i < 20; i++) begin
            step();
            cyc++;
            check("halt.req", 32'(imem_req), 32'h0);
            check("halt.hold", 32'(instruction), 32'h0);
            check("halt.pc", 32'(pc_out), 32'h3);
        end

        // Reset while stalled with a full skid.
        reset_low();
        mem[3] = 24'h100003;
        reset_release();
        goto(4);
        stall = 1'b1;
        goto(5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        stall = 1'b0;
        cyc = 0;
        expect_bubble("rst_skid_c0");
        check("rst_skid.addr", 32'(imem_addr), 32'h0);
        goto(1);
        expect_bubble("rst_skid_c1");
        goto(2);
        expect_word("rst_skid_c2", 24'h100000, 16'h0);
        goto(3);
        expect_word("rst_skid_c3", 24'h100001, 16'h1);

        // Random traffic over random memory with sparse halt words.
        reset_low();
        for (int a = 0; a < 65536; a++) begin
            w = 24'($urandom);
            if (w == 24'h0) w = 24'h1;
            if ($urandom_range(0, 39) == 0) w = 24'h0;
            mem[a] = w;
        end
        reset_release();
        for (int i = 0; i < 3000; i++) begin
            step();
            stall = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            rst_n = ($urandom_range(0, 99) >= 2);
        end
        rst_n = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
